// File: rtl/iobuf_pwr_seq.sv
// Power-up sequencer for a bank of GPIO pad buffers: drives ENABLE_H / HLD_H_N and holds per-pad static config.
// Optional HOLD (output freeze) support is built when IOBUF_PWR_SEQ_HOLD_EN is defined.
module iobuf_pwr_seq #(
  parameter int          NPADS          = 8,
  parameter int          TECH_CFG_WIDTH = 16,
  parameter int          RAMP_CYCLES    = 1024,
  parameter int          SETTLE_CYCLES  = 16,
  parameter logic [15:0] CFG_RESET      = 16'hC020,
  localparam int         AW             = (NPADS > 1) ? $clog2(NPADS) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            pwr_good,
  input  logic                            hold_req,
  input  logic                            cfg_we,
  input  logic [AW-1:0]                   cfg_addr,
  input  logic [15:0]                     cfg_wdata,
  output logic [NPADS*TECH_CFG_WIDTH-1:0] tech_cfg,
  output logic                            ready,
  output logic                            hold_ack,
  output logic [2:0]                      dbg_state
);

  localparam int CMAX = (RAMP_CYCLES > SETTLE_CYCLES) ? RAMP_CYCLES : SETTLE_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    OFF    = 3'd0,
    RAMP   = 3'd1,
    SETTLE = 3'd2,
    ACTIVE = 3'd3,
    HOLD   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          en_q, hld_q, ready_q, hold_ack_q;
  logic [15:2]   cfg_q [NPADS];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= OFF;
      cnt_q      <= '0;
      en_q       <= 1'b0;
      hld_q      <= 1'b0;
      ready_q    <= 1'b0;
      hold_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      en_q       <= (state_d == SETTLE) || (state_d == ACTIVE) || (state_d == HOLD);
      hld_q      <= (state_d == ACTIVE);
      ready_q    <= (state_d == ACTIVE);
      hold_ack_q <= (state_d == HOLD);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      OFF: begin
        if (pwr_good) begin
          state_d = RAMP;
          cnt_d   = CW'(RAMP_CYCLES - 1);
        end
      end
      RAMP: begin
        if (cnt_q == '0) begin
          state_d = SETTLE;
          cnt_d   = CW'(SETTLE_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) state_d = ACTIVE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ACTIVE: begin
`ifdef IOBUF_PWR_SEQ_HOLD_EN
        if (hold_req) state_d = HOLD;
`endif
      end
      HOLD: begin
`ifdef IOBUF_PWR_SEQ_HOLD_EN
        if (!hold_req) state_d = ACTIVE;
`else
        state_d = ACTIVE;
`endif
      end
      default: state_d = OFF;
    endcase
    // Supply loss beats every other transition.
    if ((state_q != OFF) && !pwr_good) begin
      state_d = OFF;
      cnt_d   = '0;
    end
  end

  // Config writes ignore FSM state; the index compare drops out-of-range addresses.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NPADS; i++) cfg_q[i] <= CFG_RESET[15:2];
    end else if (cfg_we) begin
      for (int i = 0; i < NPADS; i++) begin
        if (cfg_addr == AW'(i)) cfg_q[i] <= cfg_wdata[15:2];
      end
    end
  end

  for (genvar g = 0; g < NPADS; g++) begin : g_pad
    assign tech_cfg[TECH_CFG_WIDTH*g +: TECH_CFG_WIDTH] = {cfg_q[g], en_q, hld_q};
  end

  assign ready     = ready_q;
  assign hold_ack  = hold_ack_q;
  assign dbg_state = state_q;

  logic unused_wdata_lo;
  assign unused_wdata_lo = ^cfg_wdata[1:0];
`ifndef IOBUF_PWR_SEQ_HOLD_EN
  logic unused_hold_req;
  assign unused_hold_req = hold_req;
`endif

endmodule

// File: doc/iobuf_pwr_seq.md
IOBUF_PWR_SEQ -- requirements
Module: iobuf_pwr_seq

Interface
REQ-001 Parameter NPADS, default 8: number of GPIO pad buffers sequenced, range 1..64.
REQ-002 Parameter TECH_CFG_WIDTH, default 16: per-pad tech_cfg width; the block supports only 16.
REQ-003 Parameter RAMP_CYCLES, default 1024: cycles from pwr_good high to ENABLE_H assertion, minimum 1.
REQ-004 Parameter SETTLE_CYCLES, default 16: cycles from ENABLE_H assertion to HLD_H_N release, minimum 1.
REQ-005 Parameter CFG_RESET, default 16'hC020: reset value of each pad's static config (DM=3'b110, ENABLE_VDDIO=1).
REQ-006 Ports: clk, in, 1, sole clock; all state changes on the rising edge.
REQ-007 Ports: rst, in, 1, reset; synchronous, active-high.
REQ-008 Ports: pwr_good, in, 1, I/O supply stable.
REQ-009 Ports: hold_req, in, 1, request to freeze all pad outputs.
REQ-010 Ports: cfg_we, in, 1, static config write strobe.
REQ-011 Ports: cfg_addr, in, max(1,$clog2(NPADS)), pad index.
REQ-012 Ports: cfg_wdata, in, 16, static config word.
REQ-013 Ports: tech_cfg, out, NPADS*16, pad i occupies bits [16*i+15:16*i]; bit0=HLD_H_N, bit1=ENABLE_H, bits 2-15 per the pad tech_cfg map.
REQ-014 Ports: ready, out, 1, pads enabled and outputs live.
REQ-015 Ports: hold_ack, out, 1, pads frozen.

Function
REQ-016 FSM states SHALL be OFF, RAMP, SETTLE, ACTIVE, HOLD, held in a registered state variable.
REQ-017 OFF: ENABLE_H=0, HLD_H_N=0 on all pads; on pwr_good=1, go to RAMP and load counter with RAMP_CYCLES-1.
REQ-018 RAMP: decrement counter each cycle; at 0, go to SETTLE and load counter with SETTLE_CYCLES-1; ENABLE_H=0, HLD_H_N=0.
REQ-019 SETTLE: ENABLE_H=1, HLD_H_N=0; decrement counter; at 0, go to ACTIVE.
REQ-020 ACTIVE: ENABLE_H=1, HLD_H_N=1, ready=1; on hold_req=1, go to HOLD.
REQ-021 HOLD: ENABLE_H=1, HLD_H_N=0, hold_ack=1, ready=0; on hold_req=0, return to ACTIVE.
REQ-022 In any state other than OFF, pwr_good=0 SHALL force OFF on the next edge, overriding every other transition.
REQ-023 Bits 0 and 1 of every pad's tech_cfg SHALL derive only from the FSM state, identically for all pads.
REQ-024 Bits 15:2 of pad i SHALL equal bits 15:2 of its static config register.
REQ-025 When cfg_we=1 and cfg_addr<NPADS, bits 15:2 of register cfg_addr SHALL load cfg_wdata[15:2], visible on tech_cfg the following cycle.
REQ-026 cfg_wdata[1:0] SHALL be ignored; writes with cfg_addr>=NPADS SHALL be dropped without side effects.
REQ-027 Config writes SHALL be accepted in every state and SHALL be independent of FSM transitions in the same cycle.
REQ-028 All outputs SHALL be registered, with no combinational path from input to output.
REQ-029 hold_req asserted in OFF, RAMP or SETTLE SHALL be ignored; if it is still high on entry to ACTIVE, the FSM SHALL go to HOLD on the next edge.

Reset
REQ-030 With rst=1 at an edge: state=OFF, counter=0, all static registers=CFG_RESET, ready=0, hold_ack=0.
REQ-031 Following reset, bits 1:0 of tech_cfg SHALL be 2'b00 for every pad.
REQ-032 rst SHALL override pwr_good, hold_req and cfg_we in the same cycle, including during RAMP, SETTLE or HOLD.

Configuration
REQ-033 Macro IOBUF_PWR_SEQ_HOLD_EN defined: the HOLD state and hold_req/hold_ack behave per REQ-021 and REQ-029.
REQ-034 Macro IOBUF_PWR_SEQ_HOLD_EN undefined: HOLD is not implemented, hold_req is ignored, hold_ack is tied 0, and ACTIVE persists until pwr_good=0 or rst.

Verification
REQ-035 Default parameters, rst then pwr_good=1: ENABLE_H rises exactly 1024 cycles after the first pwr_good=1 edge; HLD_H_N and ready rise 16 cycles later.
REQ-036 pwr_good dropped during RAMP count 500: next cycle state=OFF and tech_cfg[1:0]=0; re-asserting pwr_good restarts the full 1024-cycle ramp.
REQ-037 ACTIVE with HOLD_EN defined, hold_req=1 for 5 cycles: HLD_H_N=0 and hold_ack=1 for 5 cycles, then HLD_H_N=1 and ready=1.
REQ-038 Write cfg_addr=3, cfg_wdata=16'hFFFF while in SETTLE: pad 3 reads 16'hFFFE next cycle; other pads stay 16'hC022.
REQ-039 Write with cfg_addr=NPADS: no tech_cfg bit changes.
REQ-040 rst pulse during HOLD: next cycle every pad reads 16'hC020, ready=0, hold_ack=0.
